// File: rtl/fiat_25519_carry_mul_mul_pipe.sv
// fiat_25519_carry_mul_mul_pipe: pipelined signed/unsigned multiplier with
// valid/ready handshakes on both sides and bubble-collapsing back-pressure.
// Optional overflow flag output enabled by defining FIAT_MUL_PIPE_OVF_EN.
module fiat_25519_carry_mul_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 39,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 44
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  sgn,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_vld,
`ifdef FIAT_MUL_PIPE_OVF_EN
  output logic                  ovf,
`endif
  input  logic                  out_rdy
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  // Instance tag has no functional effect.
  localparam int unused_id = ID;

  logic [PW-1:0]         a_ext;
  logic [PW-1:0]         b_ext;
  logic [PW-1:0]         prod_full;
  logic [NUM_STAGE-1:0]  rdy;
  logic                  rdy_chain;
  logic [NUM_STAGE-1:0]  v_q, v_d;
  logic [dout_WIDTH-1:0] p_q [NUM_STAGE];
  logic [dout_WIDTH-1:0] p_d [NUM_STAGE];

  // Operand extension and full-width product; the low PW bits of the
  // extended product are exact for both signed and unsigned operands.
  always_comb begin
    if (sgn) begin
      a_ext = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
      b_ext = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
    end else begin
      a_ext = {{din1_WIDTH{1'b0}}, din0};
      b_ext = {{din0_WIDTH{1'b0}}, din1};
    end
    prod_full = a_ext * b_ext;
  end

  // Ready chain from the output back to the input; an empty slot never blocks.
  always_comb begin
    rdy       = '0;
    rdy_chain = out_rdy;
    for (int i = NUM_STAGE - 1; i >= 0; i--) begin
      rdy[i]    = !v_q[i] | rdy_chain;
      rdy_chain = rdy[i];
    end
  end

  assign in_rdy  = rdy[0] & ~ap_rst;
  assign out_vld = v_q[NUM_STAGE-1];
  assign dout    = p_q[NUM_STAGE-1];

  // Slot advance: each ready slot loads its predecessor (slot 0 loads the input).
  always_comb begin
    v_d = v_q;
    p_d = p_q;
    if (rdy[0]) begin
      v_d[0] = in_vld;
      p_d[0] = prod_full[dout_WIDTH-1:0];
    end
    for (int i = 1; i < NUM_STAGE; i++) begin
      if (rdy[i]) begin
        v_d[i] = v_q[i-1];
        p_d[i] = p_q[i-1];
      end
    end
  end

  // Pipeline registers, cleared asynchronously.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v_q <= '0;
      for (int i = 0; i < NUM_STAGE; i++) p_q[i] <= '0;
    end else begin
      v_q <= v_d;
      p_q <= p_d;
    end
  end

`ifdef FIAT_MUL_PIPE_OVF_EN
  logic                 ovf_in;
  logic [NUM_STAGE-1:0] o_q, o_d;

  // Overflow: discarded upper bits are not zero (unsigned) or not copies of
  // the kept sign bit (signed).
  always_comb begin
    ovf_in = 1'b0;
    for (int i = dout_WIDTH; i < PW; i++) begin
      if (sgn) ovf_in = ovf_in | (prod_full[i] ^ prod_full[dout_WIDTH-1]);
      else     ovf_in = ovf_in | prod_full[i];
    end
  end

  // Overflow flag travels with its product through the same slots.
  always_comb begin
    o_d = o_q;
    if (rdy[0]) o_d[0] = ovf_in;
    for (int i = 1; i < NUM_STAGE; i++) begin
      if (rdy[i]) o_d[i] = o_q[i-1];
    end
  end

  // Overflow flag registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) o_q <= '0;
    else        o_q <= o_d;
  end

  assign ovf = o_q[NUM_STAGE-1];
`else
  logic unused_prod;
  assign unused_prod = ^prod_full;
`endif

endmodule

// File: doc/fiat_25519_carry_mul_mul_pipe.md
# fiat_25519_carry_mul_mul_pipe

Parametrised, pipelined integer multiplier with valid/ready handshakes on both sides. It replaces the fixed-width, purely combinational multiplier cores used inside the `fiat_25519_carry_mul` datapath. Width, pipeline depth and signedness are selectable, and back-pressure stalls the pipeline without losing results. It sits between the limb-product scheduler (upstream) and the carry/reduction accumulator (downstream).

## Interface
- `ID`, default 1: instance tag; no functional effect.
- `NUM_STAGE`, default 2: pipeline register stages. Legal range is 1..4.
- `din0_WIDTH`, default 39: width of operand A.
- `din1_WIDTH`, default 6: width of operand B.
- `dout_WIDTH`, default 44: result width. Must be ≤ din0_WIDTH+din1_WIDTH.

Ports:
- `ap_clk`  in  1  single clock; all state changes on the rising edge.
- `ap_rst`  in  1  reset, asynchronous and active-high.
- `din0`  in  din0_WIDTH  operand A.
- `din1`  in  din1_WIDTH  operand B.
- `sgn`  in  1  1 = both operands two's complement; 0 = both unsigned.
- `in_vld`  in  1  operands valid.
- `in_rdy`  out  1  block can accept operands this cycle.
- `dout`  out  dout_WIDTH  product.
- `out_vld`  out  1  `dout` valid.
- `out_rdy`  in  1  downstream accepts `dout` this cycle.

## Operation
- **Product computation.** The full product is formed combinationally at the input with width din0_WIDTH+din1_WIDTH. Each operand is sign- or zero-extended according to `sgn`.
- **Truncation.** `dout` is the low dout_WIDTH bits of the full product. There is no saturation.
- **Pipeline storage.**
  - The pipeline is NUM_STAGE slots; each slot holds {valid, product}.
  - Slot 1 loads from the input, and slot N drives `dout`/`out_vld`.
- **Ready chain (bubble-collapsing).**
  - rdy[N] = `out_rdy`.
  - rdy[i] = !v[i] | rdy[i+1].
  - `in_rdy` = rdy[1].
- **Slot advance.** Slot i loads slot i−1 (or the input, for i=1) when rdy[i] is high. It becomes valid if the source was valid, and otherwise becomes empty.
- **Transfer rules.**
  - An input is accepted when `in_vld` & `in_rdy`.
  - An output is consumed when `out_vld` & `out_rdy`.
- **Throughput and capacity.** Throughput is one product per cycle. Up to NUM_STAGE results may be buffered.
- **Ordering.** Results leave in acceptance order; nothing is dropped or duplicated.
- **`dout` stability.** `dout` holds its value while `out_vld`=1 and `out_rdy`=0.

## Timing
- **Reset values:** `ap_rst`=1 clears all valid bits and product registers immediately (asynchronous). During reset, `out_vld`=0, `dout`=0 and `in_rdy`=0.
- **`in_rdy` after reset:** `in_rdy` rises combinationally once `ap_rst` is deasserted.
- **Reset mid-operation:** in-flight products are discarded, and the first output after reset comes from a post-reset input.
- **Latency:** an input accepted in cycle t is presented with `out_vld`=1 in cycle t+NUM_STAGE, given no back-pressure.
- **Full pipeline:** with all slots valid and `out_rdy`=0, `in_rdy`=0 in the same cycle.
- **Simultaneous events:** when full with `out_rdy`=1, `in_rdy`=1, so a consume and an accept happen in the same cycle.
- **Empty pipeline:** an empty slot never blocks, so `in_rdy`=1 whenever any slot is empty or the pipeline is draining.
- **Combinational paths:** the `out_rdy`→`in_rdy` path is combinational through NUM_STAGE OR gates. No other input→output combinational path exists.

## Configuration
- Macro: `FIAT_MUL_PIPE_OVF_EN`.
- **When defined:**
  - An extra output `ovf` (1 bit) is added, carried alongside each product through the pipeline.
  - `ovf`=1 when the full product is not representable in dout_WIDTH bits under the current `sgn` interpretation (unsigned: upper bits nonzero; signed: upper bits not a sign-extension of bit dout_WIDTH−1).
  - `ovf` has reset value 0 and is valid only with `out_vld`.
- **When undefined:** the port and its logic are absent. Behaviour is otherwise identical.

## Test plan
All scenarios use default parameters unless noted.
- **Basic product:** NUM_STAGE=2, `sgn`=0, din0=1000, din1=5, `in_vld` pulse at t0 → `out_vld` at t0+2, `dout`=0x00000001388, `ovf`=0.
- **Unsigned truncation:** `sgn`=0, din0=0x7FFFFFFFFF, din1=0x3F → `dout`=0xF7FFFFFFFC1, `ovf`=1.
- **Signed mode:** `sgn`=1 with the same operands (−1 × −1) → `dout`=0x00000000001, `ovf`=0.
- **Back-pressure:** NUM_STAGE=3, stream 6 inputs (values 1..6 × 2) with `out_rdy`=0 for 8 cycles.
  - `in_rdy` falls after exactly 3 accepts.
  - After `out_rdy`=1, outputs are 2,4,6,8,10,12 in order at one per cycle, with `dout` stable while stalled.
- **Reset mid-stream:** assert `ap_rst` asynchronously, between edges, with 2 slots valid → `out_vld`=0 and `dout`=0 immediately. After release, the first output equals the first post-reset input's product.
- **Sweep:** NUM_STAGE=1 and 4 with random `in_vld`/`out_rdy`, 10k transactions → matches the reference model with no loss or reorder, and latency = NUM_STAGE when unstalled.
